// File: rtl/ic12_pkg.sv
// Shared definitions for interrupt_controller12: register map, request FSM
// encoding and STATUS field positions.
package ic12_pkg;

    localparam int N_MAX = 24;

    localparam logic [3:0] A_PEND_L  = 4'd0;
    localparam logic [3:0] A_PEND_H  = 4'd1;
    localparam logic [3:0] A_MASK_L  = 4'd2;
    localparam logic [3:0] A_MASK_H  = 4'd3;
    localparam logic [3:0] A_EDGE_L  = 4'd4;
    localparam logic [3:0] A_EDGE_H  = 4'd5;
    localparam logic [3:0] A_STATUS  = 4'd6;
    localparam logic [3:0] A_EOI     = 4'd7;
    localparam logic [3:0] A_VBASE_L = 4'd8;
    localparam logic [3:0] A_VBASE_H = 4'd9;

    localparam int ST_IN_SERVICE = 11;
    localparam int ST_IRQ_REQ    = 10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/ic12_prio_enc.sv
// Combinational lowest-index-wins priority encoder over the 24 request lines.
module ic12_prio_enc
    import ic12_pkg::*;
(
    input  logic [N_MAX-1:0] req,
    output logic [4:0]       id,
    output logic             valid
);

    always_comb begin
        id    = '0;
        valid = |req;
        // Scan downward so the lowest set index is the last assignment.
        for (int i = N_MAX - 1; i >= 0; i--) begin
            if (req[i]) id = 5'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller12.sv
// Interrupt controller: edge/level pending, mask, lowest-index arbitration and
// a REQ/SERVICE handshake toward the core, configured via a 12-bit register window.
module interrupt_controller12
    import ic12_pkg::*;
#(
    parameter int N_IRQ           = 24,
    parameter int VEC_STRIDE_LOG2 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic [3:0]       reg_addr,
    input  logic [11:0]      reg_wdata,
    input  logic             reg_we,
    output logic [11:0]      reg_rdata,
    output logic             irq_req,
    output logic [4:0]       irq_id,
    output logic [23:0]      irq_vector,
    input  logic             irq_ack
);

    localparam logic [N_MAX-1:0] IMPL = N_MAX'((25'd1 << N_IRQ) - 25'd1);

    state_t            state, state_nxt;
    logic [N_MAX-1:0]  mask, edge_mode, pend_edge, src_prev, vbase;
    logic [N_MAX-1:0]  mask_nxt, edge_nxt, vbase_nxt, w1c, ack_clr;
    logic [N_MAX-1:0]  src, rise, pend, eligible;
    logic              in_service, eoi, latch, ack_take;
    logic [4:0]        active_id, win_id;
    logic              win_valid;
    logic [11:0]       rd_nxt;

    assign src      = N_MAX'(irq_src) & IMPL;
    assign rise     = src & ~src_prev & edge_mode;
    assign pend     = ((pend_edge & edge_mode) | (src & ~edge_mode)) & IMPL;
    assign eligible = pend & ~mask;
    assign ack_clr  = ack_take ? ((N_MAX'(1) << irq_id) & edge_mode) : '0;

    ic12_prio_enc u_enc (
        .req   (eligible),
        .id    (win_id),
        .valid (win_valid)
    );

    always_comb begin
        mask_nxt  = mask;
        edge_nxt  = edge_mode;
        vbase_nxt = vbase;
        w1c       = '0;
        eoi       = 1'b0;
        if (reg_we) begin
            case (reg_addr)
                A_PEND_L:  w1c[11:0]        = reg_wdata;
                A_PEND_H:  w1c[23:12]       = reg_wdata;
                A_MASK_L:  mask_nxt[11:0]   = reg_wdata;
                A_MASK_H:  mask_nxt[23:12]  = reg_wdata;
                A_EDGE_L:  edge_nxt[11:0]   = reg_wdata;
                A_EDGE_H:  edge_nxt[23:12]  = reg_wdata;
                A_EOI:     eoi              = 1'b1;
                A_VBASE_L: vbase_nxt[11:0]  = reg_wdata;
                A_VBASE_H: vbase_nxt[23:12] = reg_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        ack_take  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!in_service && win_valid) begin
                    state_nxt = S_REQ;
                    latch     = 1'b1;
                end
            end
            S_REQ: begin
                // Ack wins over a same-cycle withdrawal: the core has committed.
                if (irq_ack) begin
                    state_nxt = S_SERVICE;
                    ack_take  = 1'b1;
                end else if ((eligible & (N_MAX'(1) << irq_id)) == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SERVICE: if (eoi) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (reg_addr)
            A_PEND_L:  rd_nxt = pend[11:0];
            A_PEND_H:  rd_nxt = pend[23:12];
            A_MASK_L:  rd_nxt = mask[11:0];
            A_MASK_H:  rd_nxt = mask[23:12];
            A_EDGE_L:  rd_nxt = edge_mode[11:0];
            A_EDGE_H:  rd_nxt = edge_mode[23:12];
            A_STATUS:  rd_nxt = {in_service, irq_req, 5'b0, active_id};
            A_VBASE_L: rd_nxt = vbase[11:0];
            A_VBASE_H: rd_nxt = vbase[23:12];
            default:   rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            mask       <= '1;
            edge_mode  <= '0;
            pend_edge  <= '0;
            src_prev   <= '0;
            vbase      <= '0;
            in_service <= 1'b0;
            active_id  <= '0;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            irq_vector <= '0;
            reg_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            mask      <= mask_nxt;
            edge_mode <= edge_nxt;
            vbase     <= vbase_nxt;
            src_prev  <= src;
            reg_rdata <= rd_nxt;
            irq_req   <= (state_nxt == S_REQ);
            // New edges beat clears; lines leaving edge mode drop their latch.
            pend_edge <= ((pend_edge & ~(w1c | ack_clr)) | rise) & edge_nxt & IMPL;
            if (ack_take) begin
                in_service <= 1'b1;
                active_id  <= irq_id;
            end else if (eoi) begin
                in_service <= 1'b0;
            end
            if (latch) begin
                irq_id     <= win_id;
                irq_vector <= vbase + (N_MAX'(win_id) << VEC_STRIDE_LOG2);
            end
        end
    end

endmodule
